ac_e_unit: RTL and testbench

- Parametrised accumulator register with attached extend bit E.
- Generalises the single E flip-flop to a WIDTH-bit register plus E, with:
  - per-cycle register-reference ops (load, clear, increment, complement, circulate left/right through E);
  - independent E ops;
  - a multi-cycle N-position rotate-through-E engine with busy/done handshake.
- Sits in the datapath between the ALU/bus and the control sequencer, replacing the separate AC and E storage.

---
 rtl/ac_e_unit.sv | 135 +++++++++++++
 tb/tb_ac_e_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ac_e_unit.sv
// Accumulator register with attached extend bit E, per-cycle register-reference ops,
// and a multi-cycle N-position rotate-through-E engine with busy/done handshake.
module ac_e_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [1:0]       e_op,
    input  logic [WIDTH-1:0] d_in,
    input  logic             e_in,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             e_out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROT,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_CLR  = 3'b010,
        OP_INC  = 3'b011,
        OP_CMA  = 3'b100,
        OP_CIR  = 3'b101,
        OP_CIL  = 3'b110,
        OP_ROTN = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        E_HOLD = 2'b00,
        E_CLR  = 2'b01,
        E_CMP  = 2'b10,
        E_LOAD = 2'b11
    } e_op_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic             rot_dir;
    logic [SHW-1:0]   shamt_sat;
    logic             op_owns_e;

    // Out-of-range counts are illegal; saturate rather than wrap.
    assign shamt_sat = (shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt;
    assign op_owns_e = (op == OP_CIR) || (op == OP_CIL) || (op == OP_ROTN);
    assign zero      = (q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            q       <= '0;
            e_out   <= 1'b0;
            cnt     <= '0;
            rot_dir <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        case (op)
                            OP_LOAD: q <= d_in;
                            OP_CLR:  q <= '0;
                            OP_INC:  q <= q + 1'b1;
                            OP_CMA:  q <= ~q;
                            OP_CIR: begin
                                q     <= {e_out, q[WIDTH-1:1]};
                                e_out <= q[0];
                            end
                            OP_CIL: begin
                                q     <= {q[WIDTH-2:0], e_out};
                                e_out <= q[WIDTH-1];
                            end
                            OP_ROTN: begin
                                cnt     <= shamt_sat;
                                rot_dir <= dir;
                                if (shamt_sat == '0) begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= S_ROT;
                                    busy  <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                        if (!op_owns_e) begin
                            case (e_op)
                                E_CLR:  e_out <= 1'b0;
                                E_CMP:  e_out <= ~e_out;
                                E_LOAD: e_out <= e_in;
                                default: ;
                            endcase
                        end
                    end
                end
                S_ROT: begin
                    if (rot_dir) begin
                        q     <= {q[WIDTH-2:0], e_out};
                        e_out <= q[WIDTH-1];
                    end else begin
                        q     <= {e_out, q[WIDTH-1:1]};
                        e_out <= q[0];
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ac_e_unit.sv
// Scoreboard bench for ac_e_unit: drivers queue expected {q,E}, a monitor pops and
// compares on each op result strobe or done pulse.
module tb_ac_e_unit;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SHW   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic [2:0]       op = '0;
    logic [1:0]       e_op = '0;
    logic [WIDTH-1:0] d_in = '0;
    logic             e_in = 1'b0;
    logic [SHW-1:0]   shamt = '0;
    logic             dir = 1'b0;
    logic [WIDTH-1:0] q;
    logic             e_out, zero, busy, done;

    ac_e_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .e_op(e_op), .d_in(d_in),
        .e_in(e_in), .shamt(shamt), .dir(dir), .q(q), .e_out(e_out),
        .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            nm;
        logic [WIDTH-1:0] q;
        logic             e;
    } exp_t;

    exp_t op_q[$];
    exp_t rot_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    logic chk_pulse = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic compare_exp(input exp_t x);
        check({x.nm, ".q"}, 32'(q), 32'(x.q));
        check({x.nm, ".e"}, 32'(e_out), 32'(x.e));
        check({x.nm, ".zero"}, 32'(zero), 32'(x.q == '0));
    endtask

    // Monitor: decoupled from the drivers, pops on result strobes.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (rot_q.size() == 0) check("unexpected_done", 32'(done), 32'(0));
            else compare_exp(rot_q.pop_front());
        end
        if (chk_pulse) begin
            if (op_q.size() == 0) check("unexpected_result", 32'(chk_pulse), 32'(0));
            else compare_exp(op_q.pop_front());
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [1:0] eo, input logic [WIDTH-1:0] d,
                         input logic ei, input logic [WIDTH-1:0] eq, input logic ee,
                         input string nm);
        op = o; e_op = eo; d_in = d; e_in = ei; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0; op = '0; e_op = '0;
        op_q.push_back('{nm, eq, ee});
        chk_pulse = 1'b1;
        @(negedge clk); #1;
        chk_pulse = 1'b0;
    endtask

    // Issues ROTN; optionally holds a LOAD request on the inputs while busy.
    task automatic do_rot(input int n, input logic dr, input logic [WIDTH-1:0] eq,
                          input logic ee, input bit poke, input string nm);
        int w;
        int d0;
        rot_q.push_back('{nm, eq, ee});
        busy_cnt = 0;
        d0 = done_cnt;
        op = 3'b111; shamt = SHW'(n); dir = dr; en = 1'b1;
        @(posedge clk); #1;
        if (poke) begin
            op = 3'b001; e_op = 2'b11; d_in = 16'h1234; e_in = 1'b0; en = 1'b1;
        end else begin
            en = 1'b0; op = '0;
        end
        w = 0;
        while (!done && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        en = 1'b0; op = '0; e_op = '0;
        check({nm, ".latency"}, 32'(w), 32'(n));
        @(posedge clk); #1;
        check({nm, ".done_cnt"}, 32'(done_cnt - d0), 32'(1));
        check({nm, ".busy_cycles"}, 32'(busy_cnt), 32'(n));
        check({nm, ".done_low"}, 32'(done), 32'(0));
    endtask

    initial begin
        int d0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.q", 32'(q), 32'(0));
        check("rst.e", 32'(e_out), 32'(0));
        check("rst.busy", 32'(busy), 32'(0));
        check("rst.done", 32'(done), 32'(0));
        check("rst.zero", 32'(zero), 32'(1));
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;

        // Asynchronous reset with no clock edge
        do_op(3'b001, 2'b11, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, "load_beef");
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("arst.q", 32'(q), 32'(0));
        check("arst.e", 32'(e_out), 32'(0));
        check("arst.zero", 32'(zero), 32'(1));
        check("arst.busy", 32'(busy), 32'(0));
        check("arst.done", 32'(done), 32'(0));
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;

        // Circulate through E; e_op is ignored under CIR/CIL
        do_op(3'b001, 2'b11, 16'h8001, 1'b1, 16'h8001, 1'b1, "load_8001");
        do_op(3'b110, 2'b01, 16'h0000, 1'b0, 16'h0003, 1'b1, "cil");
        do_op(3'b101, 2'b01, 16'h0000, 1'b0, 16'h8001, 1'b1, "cir");

        do_op(3'b001, 2'b01, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, "load_ffff");
        do_op(3'b011, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0, "inc_wrap");
        do_op(3'b001, 2'b00, 16'h00FF, 1'b0, 16'h00FF, 1'b0, "load_00ff");
        do_op(3'b100, 2'b00, 16'h0000, 1'b0, 16'hFF00, 1'b0, "cma");
        do_op(3'b010, 2'b10, 16'h0000, 1'b0, 16'h0000, 1'b1, "clr_ecmp");
        do_op(3'b000, 2'b10, 16'hAAAA, 1'b0, 16'h0000, 1'b0, "nop_ecmp");
        en = 1'b0;
        do_op(3'b001, 2'b11, 16'h5555, 1'b1, 16'h5555, 1'b1, "load_5555");
        en = 1'b0; op = 3'b010; e_op = 2'b01;
        @(posedge clk); #1;
        op = '0; e_op = '0;
        check("en_low.q", 32'(q), 32'(16'h5555));
        check("en_low.e", 32'(e_out), 32'(1));

        // ROTN right by 4 with a LOAD request held during busy
        do_op(3'b001, 2'b01, 16'h000F, 1'b0, 16'h000F, 1'b0, "load_000f");
        do_rot(4, 1'b0, 16'hE000, 1'b1, 1'b1, "rotr4");
        do_rot(0, 1'b0, 16'hE000, 1'b1, 1'b0, "rot0");

        // 16 left then 1 left: 17 steps around the 17-bit ring restores the value
        do_op(3'b001, 2'b11, 16'hA5A5, 1'b1, 16'hA5A5, 1'b1, "load_a5a5");
        do_rot(16, 1'b1, 16'hD2D2, 1'b1, 1'b0, "rotl16");
        do_rot(1, 1'b1, 16'hA5A5, 1'b1, 1'b0, "rotl1");

        // Reset during step 2 of an 8-step rotation
        do_op(3'b001, 2'b01, 16'h1234, 1'b0, 16'h1234, 1'b0, "load_1234");
        d0 = done_cnt;
        op = 3'b111; shamt = SHW'(8); dir = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0; op = '0;
        @(posedge clk); #1;
        check("mid.busy", 32'(busy), 32'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort.q", 32'(q), 32'(0));
        check("abort.e", 32'(e_out), 32'(0));
        check("abort.busy", 32'(busy), 32'(0));
        check("abort.done", 32'(done), 32'(0));
        @(negedge clk); reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort.no_done", 32'(done_cnt - d0), 32'(0));
        check("abort.idle_busy", 32'(busy), 32'(0));

        do_op(3'b001, 2'b01, 16'h0001, 1'b0, 16'h0001, 1'b0, "load_0001");
        do_rot(2, 1'b1, 16'h0004, 1'b0, 1'b0, "rotl2_after_abort");

        repeat (3) @(posedge clk);
        #1;
        check("op_q_empty", 32'(op_q.size()), 32'(0));
        check("rot_q_empty", 32'(rot_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
